systolic_array: RTL and testbench
=================================

Name:
systolic_array

Overview:
- Output-stationary SIZE x SIZE systolic array that computes C = A x B for two SIZE x SIZE unsigned matrices streamed in skewed (wavefront) order.
- Each processing element (PE) multiplies with a radix-4 (modified Booth) multiplier and accumulates locally.
- Sits as the matrix-multiply compute core. An upstream feeder supplies the skewed row/column streams; a downstream consumer reads the flat C bus once done is high.

Parameters:
- SIZE, 8, array dimension (rows = columns = SIZE; also the inner dimension K).
- DATA_WIDTH, 8, operand width in bits (unsigned); accumulators are 2*DATA_WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  SIZE*DATA_WIDTH  left-edge stream; slice i = A[i*DATA_WIDTH +: DATA_WIDTH] feeds row i.
- B  input  SIZE*DATA_WIDTH  top-edge stream; slice j = B[j*DATA_WIDTH +: DATA_WIDTH] feeds column j.
- done  output  1  result-valid flag, sticky until reset.
- C  output  SIZE*SIZE*2*DATA_WIDTH  accumulators; C[(i*SIZE+j)*2*DATA_WIDTH +: 2*DATA_WIDTH] = element (i,j).

Behaviour:
- Reset (rst=1 at a rising edge):
  - All PE accumulators, forwarded a/b registers and the cycle counter go to 0.
  - Hence C=0 and done=0 in the cycle after reset.
  - Reset asserted mid-computation aborts it with the same effect; the next computation starts on the first edge with rst=0.
- Stream timing: edge t = 0 is the first rising edge with rst=0.
  - Feeder presents matrix element Am[i][k] on A slice i at edge k+i.
  - Feeder presents Bm[k][j] on B slice j at edge k+j.
  - Slices are 0 outside these windows.
- PE(i,j) inputs:
  - a_in = A slice i when j=0, else PE(i,j-1).a_reg.
  - b_in = B slice j when i=0, else PE(i-1,j).b_reg.
- PE(i,j) on each rising edge with rst=0:
  - acc <= acc + a_in*b_in, truncated to 2*DATA_WIDTH bits (modulo wrap, no saturation).
  - a_reg <= a_in; b_reg <= b_in.
  - Net effect: one-cycle hop per PE, so operands pair at PE(i,j) on edge k+i+j.
- Multiplier:
  - Combinational radix-4 Booth; operands are zero-extended by 2 bits to be treated as unsigned.
  - Produces ceil((DATA_WIDTH+2)/2) partial products (5 for 8-bit), with digits in {-2,-1,0,+1,+2}.
  - Summed result must equal the exact unsigned product for all 2^(2*DATA_WIDTH) operand pairs.
- Counter:
  - Increments on each non-reset edge and saturates at 3*SIZE-2.
  - done = (counter == 3*SIZE-2), registered; rises on edge 3*SIZE-3, i.e. after 3*SIZE-2 non-reset edges (22 for SIZE=8).
  - The last products (k=SIZE-1 at PE(SIZE-1,SIZE-1)) accumulate on that same edge, so C is final when done first reads 1.
- After done:
  - PEs keep accumulating whatever arrives.
  - The feeder must drive zeros, which leaves C stable.
  - A new matrix requires a reset pulse.
- C is driven directly from the accumulator registers (no extra output register).

Test Plan:
- Reset: hold rst=1 for 2 edges with nonzero A/B -> C=0, done=0; release rst, drive zeros for 22 edges -> done=1 on edge 21, C=0.
- Reference 8x8 product:
  - Stream row 0 of Am = 37,60,1,5,52,23,44,50 and column 0 of Bm = 2,47,2,5,16,48,46,53, with the other rows/columns random, skewed per timing.
  - -> C(0,0)=9531 (0x253B); every C(i,j) matches the software model when done rises.
- Single element: Am[7][7]=255 and Bm[7][7]=255, all else 0 -> C(7,7)=65025 (0xFE01) exactly at done, all other C=0.
- Wrap: all operands 255 -> every C(i,j)=520200 mod 65536=61448 (0xF008).
- Reset mid-run: assert rst at edge 10 for 1 cycle, then re-stream identity Am and Bm=k -> C=k element-wise; done rises 22 edges after the reset release.
- Booth exhaustive: force a single PE with all 65536 (a,b) pairs over fresh resets -> acc = a*b for every pair, including 0x80, 0xFF and 0xAA.

Source files
------------

// File: rtl/systolic_array.sv
// ---------------------------------------------------------------------------
// systolic_array
//   Output-stationary SIZE x SIZE systolic array computing C = A x B for two
//   unsigned SIZE x SIZE matrices fed in skewed (wavefront) order. Each PE
//   multiplies its operand pair with a radix-4 Booth multiplier, adds the
//   product into a local 2*DATA_WIDTH accumulator (modulo wrap), and forwards
//   the a operand right and the b operand down with a one-cycle hop.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears accumulators, forwarding
//           registers and the cycle counter)
//   A     : left-edge stream, slice i feeds row i
//   B     : top-edge stream, slice j feeds column j
//   done  : result-valid flag, sticky until reset
//   C     : flat accumulator bus, element (i,j) at slice i*SIZE+j
// ---------------------------------------------------------------------------

module systolic_booth_mul #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] p
);
  // ceil((DATA_WIDTH+2)/2) digits: the multiplier gets two zero bits on top
  // so the top digit never reads as negative for an unsigned operand.
  localparam int NUM_PP = (DATA_WIDTH + 3) / 2;
  localparam int MX_W   = 2 * NUM_PP + 1;
  localparam int SUM_W  = 2 * DATA_WIDTH + 4;

  logic [MX_W-1:0]          mx;
  logic [2:0]               digit;
  logic signed [SUM_W-1:0]  mcand;
  logic signed [SUM_W-1:0]  pp;
  logic signed [SUM_W-1:0]  sum;
  logic                     unused_sum_hi;

  // Bit 0 of mx is the implicit zero below the LSB used by the first digit.
  always_comb begin
    mx           = '0;
    mx[DATA_WIDTH:1] = b;
    mcand        = $signed({{(SUM_W-DATA_WIDTH){1'b0}}, a});
    sum          = '0;
    digit        = '0;
    pp           = '0;
    for (int k = 0; k < NUM_PP; k++) begin
      digit = mx[2*k +: 3];
      case (digit)
        3'b001, 3'b010: pp = mcand;
        3'b011:         pp = mcand <<< 1;
        3'b100:         pp = -(mcand <<< 1);
        3'b101, 3'b110: pp = -mcand;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2 * k));
    end
    p = sum[2*DATA_WIDTH-1:0];
  end

  // The unsigned product always fits in 2*DATA_WIDTH bits; the guard bits
  // only carry sign extension of intermediate partial sums.
  assign unused_sum_hi = ^sum[SUM_W-1:2*DATA_WIDTH];
endmodule

module systolic_array #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SIZE*DATA_WIDTH-1:0]       A,
  input  logic [SIZE*DATA_WIDTH-1:0]       B,
  output logic                             done,
  output logic [SIZE*SIZE*2*DATA_WIDTH-1:0] C
);
  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int LAST  = 3 * SIZE - 2;
  localparam int CNT_W = $clog2(LAST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  logic [DATA_WIDTH-1:0] a_d   [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] a_q   [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_d   [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_q   [SIZE][SIZE];
  logic [ACC_W-1:0]      prod  [SIZE][SIZE];
  logic [ACC_W-1:0]      acc_d [SIZE][SIZE];
  logic [ACC_W-1:0]      acc_q [SIZE][SIZE];
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  done_d, done_q;
  logic                  unused_edge;

  // Operand routing: edge PEs take the external streams, inner PEs take the
  // registered operand of their left / upper neighbour.
  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_d[i][j] = A[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_a_inner
        assign a_d[i][j] = a_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_d[i][j] = B[j*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_b_inner
        assign b_d[i][j] = b_q[i-1][j];
      end

      systolic_booth_mul #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_mul (
        .a(a_d[i][j]),
        .b(b_d[i][j]),
        .p(prod[i][j])
      );

      assign C[(i*SIZE+j)*ACC_W +: ACC_W] = acc_q[i][j];
    end
  end

  // Accumulate with natural wrap; the counter parks at its terminal value so
  // done stays high until the next reset.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        acc_d[i][j] = acc_q[i][j] + prod[i][j];
      end
    end
    cnt_d  = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
    done_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          a_q[i][j]   <= a_d[i][j];
          b_q[i][j]   <= b_d[i][j];
          acc_q[i][j] <= acc_d[i][j];
        end
      end
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

  // Operands leaving the right and bottom edges have no consumer.
  always_comb begin
    unused_edge = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      unused_edge = unused_edge ^ (^a_q[k][SIZE-1]) ^ (^b_q[SIZE-1][k]);
    end
  end
endmodule

// File: tb/tb_systolic_array.sv
// ---------------------------------------------------------------------------
// tb_systolic_array
//   Scoreboard bench for systolic_array. Stimulus tasks compute the expected
//   matrix product (or per-PE product stream) with plain arithmetic and push it
//   into a queue; an independent monitor pops and compares whenever the DUT
//   presents a result.
// ---------------------------------------------------------------------------
module tb_systolic_array;
  localparam int SIZE        = 8;
  localparam int DW          = 8;
  localparam int ACC_W       = 2 * DW;
  localparam int LAST        = 3 * SIZE - 2;
  localparam int BOOTH_STEPS = 65536 / SIZE;

  typedef logic [SIZE*SIZE*ACC_W-1:0] cvec_t;
  typedef logic [SIZE*ACC_W-1:0]      dvec_t;
  typedef enum {MODE_IDLE, MODE_STREAM, MODE_BOOTH} mode_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [SIZE*DW-1:0]     A = '0;
  logic [SIZE*DW-1:0]     B = '0;
  logic                   done;
  cvec_t                  C;

  systolic_array #(
    .SIZE(SIZE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .done(done),
    .C(C)
  );

  always #5 clk = ~clk;

  int               am [SIZE][SIZE];
  int               bm [SIZE][SIZE];
  cvec_t            expQ[$];
  dvec_t            boothQ[$];
  int               checkCount = 0;
  int               passCount = 0;
  int               edgeCount = 0;
  int               boothPopped = 0;
  mode_t            mode = MODE_IDLE;
  logic             prevDone = 1'b0;
  logic [ACC_W-1:0] expAcc [SIZE];

  // Non-reset edges since the last reset release.
  always @(posedge clk) begin
    if (rst) edgeCount <= 0;
    else     edgeCount <= edgeCount + 1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
  endtask

  function automatic cvec_t modelProduct();
    cvec_t r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < SIZE; k++) s += am[i][k] * bm[k][j];
        r[(i*SIZE+j)*ACC_W +: ACC_W] = ACC_W'(s);
      end
    end
    return r;
  endfunction

  function automatic int countNonzero();
    int n;
    n = 0;
    for (int e = 0; e < SIZE*SIZE; e++) if (C[e*ACC_W +: ACC_W] != '0) n++;
    return n;
  endfunction

  // Monitor: full-matrix compare when done rises, per-edge diagonal compare
  // during the Booth sweep.
  always @(negedge clk) begin
    if (!rst) begin
      if (mode == MODE_STREAM && done && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          cvec_t ex;
          ex = expQ.pop_front();
          checkOutput("doneEdge", edgeCount, LAST);
          for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
              checkOutput($sformatf("C(%0d,%0d)", i, j),
                          C[(i*SIZE+j)*ACC_W +: ACC_W], ex[(i*SIZE+j)*ACC_W +: ACC_W]);
        end
      end else if (mode == MODE_BOOTH && boothPopped < edgeCount && boothQ.size() > 0) begin
        dvec_t prods;
        prods = boothQ.pop_front();
        boothPopped++;
        for (int i = 0; i < SIZE; i++) begin
          expAcc[i] = expAcc[i] + prods[i*ACC_W +: ACC_W];
          checkOutput($sformatf("booth PE(%0d,%0d) edge %0d", i, i, edgeCount - 1),
                      C[(i*SIZE+i)*ACC_W +: ACC_W], expAcc[i]);
        end
      end
    end
    prevDone = done;
  end

  // Called just after a negedge; returns at a negedge with rst released.
  task automatic doReset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      A[i*DW +: DW] = DW'($urandom_range(1, 255));
      B[i*DW +: DW] = DW'($urandom_range(1, 255));
    end
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    checkOutput("resetDone", done, 0);
    checkOutput("resetNonzeroC", countNonzero(), 0);
    rst = 1'b0;
    A = '0;
    B = '0;
  endtask

  task automatic driveSlices(input int t);
    for (int i = 0; i < SIZE; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < SIZE) begin
        A[i*DW +: DW] = DW'(am[i][k]);
        B[i*DW +: DW] = DW'(bm[k][i]);
      end else begin
        A[i*DW +: DW] = '0;
        B[i*DW +: DW] = '0;
      end
    end
  endtask

  // abortAt < 0: full run with an expected result; otherwise stop streaming
  // after abortAt edges so the caller can reset mid-run.
  task automatic applyStimulus(input int abortAt);
    int lastT;
    lastT = (abortAt >= 0) ? abortAt - 1 : LAST + 2;
    if (abortAt < 0) expQ.push_back(modelProduct());
    for (int t = 0; t <= lastT; t++) begin
      driveSlices(t);
      @(posedge clk);
      @(negedge clk);
    end
    A = '0;
    B = '0;
    #1;
    if (abortAt < 0) checkOutput("pendingResults", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic fillRandom();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        am[i][j] = $urandom_range(0, 255);
        bm[i][j] = $urandom_range(0, 255);
      end
  endtask

  task automatic fillConst(input int av, input int bv);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        am[i][j] = av;
        bm[i][j] = bv;
      end
  endtask

  // Every diagonal PE(i,i) sees A slice i and B slice i with equal delay, so
  // eight disjoint slices of the 65536 operand pairs run in parallel.
  task automatic runBooth();
    mode = MODE_BOOTH;
    boothPopped = 0;
    for (int i = 0; i < SIZE; i++) expAcc[i] = '0;
    doReset(1);
    for (int e = 0; e < BOOTH_STEPS + SIZE; e++) begin
      dvec_t prods;
      prods = '0;
      for (int i = 0; i < SIZE; i++) begin
        int p;
        int s;
        p = i * BOOTH_STEPS + e;
        if (e < BOOTH_STEPS) begin
          A[i*DW +: DW] = DW'(p >> 8);
          B[i*DW +: DW] = DW'(p & 255);
        end else begin
          A[i*DW +: DW] = '0;
          B[i*DW +: DW] = '0;
        end
        s = e - i;
        if (s >= 0 && s < BOOTH_STEPS) begin
          p = i * BOOTH_STEPS + s;
          prods[i*ACC_W +: ACC_W] = ACC_W'((p >> 8) * (p & 255));
        end
      end
      boothQ.push_back(prods);
      @(posedge clk);
      @(negedge clk);
    end
    A = '0;
    B = '0;
    #1;
    checkOutput("boothPending", boothQ.size(), 0);
    boothQ.delete();
    mode = MODE_IDLE;
  endtask

  initial begin
    int row0 [SIZE];
    int col0 [SIZE];
    row0 = '{37, 60, 1, 5, 52, 23, 44, 50};
    col0 = '{2, 47, 2, 5, 16, 48, 46, 53};

    @(negedge clk);
    mode = MODE_STREAM;

    $display("[TB] reset with busy inputs, then zero stream");
    doReset(2);
    fillConst(0, 0);
    applyStimulus(-1);

    $display("[TB] reference product");
    doReset(1);
    fillRandom();
    for (int k = 0; k < SIZE; k++) begin
      am[0][k] = row0[k];
      bm[k][0] = col0[k];
    end
    applyStimulus(-1);

    $display("[TB] single corner element");
    doReset(1);
    fillConst(0, 0);
    am[SIZE-1][SIZE-1] = 255;
    bm[SIZE-1][SIZE-1] = 255;
    applyStimulus(-1);

    $display("[TB] accumulator wrap");
    doReset(1);
    fillConst(255, 255);
    applyStimulus(-1);

    $display("[TB] random products");
    for (int n = 0; n < 3; n++) begin
      doReset(1);
      fillRandom();
      applyStimulus(-1);
    end

    $display("[TB] reset mid-run, identity restart");
    doReset(1);
    fillRandom();
    applyStimulus(10);
    doReset(1);
    fillRandom();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) am[i][k] = (i == k) ? 1 : 0;
    applyStimulus(-1);

    $display("[TB] exhaustive Booth sweep on diagonal PEs");
    runBooth();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
